// File: rtl/alu_pkg.sv
// Opcode encoding shared by the fixed-point ALU pipeline and its bus interface.
package alu_pkg;
  localparam int OP_W = 8;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOP  = 8'd0;
  localparam op_t OP_ADD  = 8'd1;
  localparam op_t OP_SUB  = 8'd2;
  localparam op_t OP_MUL  = 8'd3;
  localparam op_t OP_AND  = 8'd4;
  localparam op_t OP_OR   = 8'd5;
  localparam op_t OP_NOT  = 8'd6;
  localparam op_t OP_XOR  = 8'd7;
  localparam op_t OP_SHL  = 8'd8;
  localparam op_t OP_SHR  = 8'd9;
  localparam op_t OP_MIN  = 8'd10;
  localparam op_t OP_MAX  = 8'd11;
  localparam op_t OP_LAST = OP_MAX;
endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between operand fetch, the ALU and writeback.
interface alu_pipe_if
  import alu_pkg::*;
#(
  parameter int W = 16
);
  logic         in_valid_in;
  logic         in_ready_out;
  op_t          INS_in;
  logic         sat_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] c_out;
  logic         c_valid_out;
  logic         c_ready_in;
  logic         ovf_out;
  logic         err_out;
  logic         ovf_sticky_out;
  logic         clr_sticky_in;

  modport slave (
    input  in_valid_in, INS_in, sat_in, a_in, b_in, c_ready_in, clr_sticky_in,
    output in_ready_out, c_out, c_valid_out, ovf_out, err_out, ovf_sticky_out
  );

  modport master (
    output in_valid_in, INS_in, sat_in, a_in, b_in, c_ready_in, clr_sticky_in,
    input  in_ready_out, c_out, c_valid_out, ovf_out, err_out, ovf_sticky_out
  );
endinterface

// File: rtl/fxp_sat.sv
// Narrows a sign-extended wide value to W bits, clamping or wrapping on overflow.
module fxp_sat #(
  parameter int IN_W = 17,
  parameter int W    = 16
) (
  input  logic [IN_W-1:0] val_i,
  input  logic            sat_i,
  output logic [W-1:0]    res_o,
  output logic            ovf_o
);
  // Value fits in W bits only if everything from the W-bit sign upward is identical.
  logic [IN_W-W:0] top;
  assign top   = val_i[IN_W-1:W-1];
  assign ovf_o = !((&top) || !(|top));

  always_comb begin
    res_o = val_i[W-1:0];
    if (ovf_o && sat_i)
      res_o = val_i[IN_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
endmodule

// File: rtl/alu_pipe.sv
// Two-stage fixed-point ALU: stage 1 registers operands, stage 2 computes and
// registers result/flags. Ready chains combinationally so a full pipe still streams.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 7,
  parameter int SHW  = $clog2(W)
) (
  input logic       CLK,
  input logic       RST,
  alu_pipe_if.slave io
);
  logic         v1_q, sat1_q;
  op_t          op1_q;
  logic [W-1:0] a1_q, b1_q;
  logic         v2_q, ovf_q, err_q, sticky_q;
  logic [W-1:0] c_q;
  logic [W-1:0] c_d;
  logic         ovf_d, err_d;
  logic         rdy2;

  assign rdy2            = !v2_q || io.c_ready_in;
  assign io.in_ready_out = !v1_q || rdy2;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v1_q <= 1'b0; sat1_q <= 1'b0; op1_q <= '0; a1_q <= '0; b1_q <= '0;
    end else if (io.in_ready_out) begin
      v1_q <= io.in_valid_in;
      if (io.in_valid_in) begin
        op1_q  <= io.INS_in;
        sat1_q <= io.sat_in;
        a1_q   <= io.a_in;
        b1_q   <= io.b_in;
      end
    end
  end

  logic signed [W-1:0]   sa, sb;
  logic [SHW-1:0]        sh;
  logic [W:0]            addsub_w;
  logic signed [2*W-1:0] prod, prod_sh;
  logic [2*W-1:0]        shl_w;
  logic [W-1:0]          addsub_r, mul_r, shl_r;
  logic                  addsub_o, mul_o, shl_o;

  assign sa       = a1_q;
  assign sb       = b1_q;
  assign sh       = b1_q[SHW-1:0];
  assign addsub_w = (op1_q == OP_SUB) ? {sa[W-1], sa} - {sb[W-1], sb}
                                      : {sa[W-1], sa} + {sb[W-1], sb};
  assign prod     = {{W{sa[W-1]}}, sa} * {{W{sb[W-1]}}, sb};
  assign prod_sh  = prod >>> FRAC;
  // Shifting the sign-extended value keeps lost bits visible above bit W-1.
  assign shl_w    = {{W{a1_q[W-1]}}, a1_q} << sh;

  fxp_sat #(.IN_W(W+1), .W(W)) u_addsub (.val_i(addsub_w), .sat_i(sat1_q), .res_o(addsub_r), .ovf_o(addsub_o));
  fxp_sat #(.IN_W(2*W), .W(W)) u_mul    (.val_i(prod_sh),  .sat_i(sat1_q), .res_o(mul_r),    .ovf_o(mul_o));
  fxp_sat #(.IN_W(2*W), .W(W)) u_shl    (.val_i(shl_w),    .sat_i(sat1_q), .res_o(shl_r),    .ovf_o(shl_o));

  always_comb begin
    c_d   = '0;
    ovf_d = 1'b0;
    err_d = 1'b0;
    case (op1_q)
      OP_NOP:         c_d = a1_q;
      OP_ADD, OP_SUB: begin c_d = addsub_r; ovf_d = addsub_o; end
      OP_MUL:         begin c_d = mul_r;    ovf_d = mul_o;    end
      OP_AND:         c_d = a1_q & b1_q;
      OP_OR:          c_d = a1_q | b1_q;
      OP_NOT:         c_d = ~a1_q;
      OP_XOR:         c_d = a1_q ^ b1_q;
      OP_SHL:         begin c_d = shl_r;    ovf_d = shl_o;    end
      OP_SHR:         c_d = sa >>> sh;
      OP_MIN:         c_d = (sa < sb) ? a1_q : b1_q;
      OP_MAX:         c_d = (sa < sb) ? b1_q : a1_q;
      default:        err_d = 1'b1;
    endcase
  end

  // Result registers only move when stage 2 is free or handing off, so a
  // stalled result stays stable.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v2_q <= 1'b0; c_q <= '0; ovf_q <= 1'b0; err_q <= 1'b0;
    end else if (rdy2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        c_q   <= c_d;
        ovf_q <= ovf_d;
        err_q <= err_d;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                         sticky_q <= 1'b0;
    else if (io.c_valid_out && io.c_ready_in && ovf_q) sticky_q <= 1'b1;
    else if (io.clr_sticky_in)                        sticky_q <= 1'b0;
  end

  assign io.c_out          = c_q;
  assign io.c_valid_out    = v2_q;
  assign io.ovf_out        = ovf_q;
  assign io.err_out        = err_q;
  assign io.ovf_sticky_out = sticky_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe against an integer-arithmetic reference.
module tb_alu_pipe;
  import alu_pkg::*;
  localparam int W    = 16;
  localparam int FRAC = 7;
  localparam int SHW  = $clog2(W);
  localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W-1));

  typedef struct packed {
    logic [W-1:0] c;
    logic         ovf;
    logic         err;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_pipe_if #(.W(W)) bus ();
  alu_pipe #(.W(W), .FRAC(FRAC)) dut (.CLK(clk), .RST(rst_n), .io(bus));

  res_t   exp_q[$];
  int     acc_q[$];
  res_t   m_e;
  int     m_acc;
  int     n_chk = 0, n_pass = 0, cyc = 0, n_out = 0;
  bit     lat_on = 1'b0;
  logic   sticky_m = 1'b0;
  logic [W-1:0] corner [6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference computed as plain signed integers, then range-checked against W bits.
  function automatic res_t model(input op_t op, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t   r;
    longint sa, sb, v;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[SHW-1:0]);
    v  = 0;
    r  = '0;
    case (op)
      OP_NOP: v = sa;
      OP_ADD: v = sa + sb;
      OP_SUB: v = sa - sb;
      OP_MUL: v = (sa * sb) >>> FRAC;
      OP_AND: v = sa & sb;
      OP_OR:  v = sa | sb;
      OP_NOT: v = ~sa;
      OP_XOR: v = sa ^ sb;
      OP_SHL: v = sa <<< sh;
      OP_SHR: v = sa >>> sh;
      OP_MIN: v = (sa < sb) ? sa : sb;
      OP_MAX: v = (sa > sb) ? sa : sb;
      default: r.err = 1'b1;
    endcase
    if (!r.err) begin
      r.ovf = (v > MAXV) || (v < MINV);
      if (r.ovf && s) v = (v > MAXV) ? MAXV : MINV;
      r.c = v[W-1:0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      sticky_m = 1'b0;
    end else begin
      chk("sticky", bus.ovf_sticky_out, sticky_m);
      if (bus.c_valid_out && bus.c_ready_in) begin
        n_out++;
        chk("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          m_e   = exp_q.pop_front();
          m_acc = acc_q.pop_front();
          chk("res_c", bus.c_out, m_e.c);
          chk("res_ovf", bus.ovf_out, m_e.ovf);
          chk("res_err", bus.err_out, m_e.err);
          if (lat_on) chk("latency", cyc - m_acc, 1);
          if (m_e.ovf) sticky_m = 1'b1;
          else if (bus.clr_sticky_in) sticky_m = 1'b0;
        end
      end else if (bus.clr_sticky_in) sticky_m = 1'b0;
      if (bus.in_valid_in && bus.in_ready_out) begin
        exp_q.push_back(model(bus.INS_in, bus.sat_in, bus.a_in, bus.b_in));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  task automatic send(input op_t op, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int   n;
    logic ok;
    n = 0;
    bus.in_valid_in = 1'b1;
    bus.INS_in = op; bus.sat_in = s; bus.a_in = a; bus.b_in = b;
    do begin
      @(negedge clk); ok = bus.in_ready_out;
      @(posedge clk); #1; n++;
    end while (!ok && n < 100);
    if (!ok) chk("send_timeout", ok, 1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.c_valid_out && n < 20);
    chk("wait_valid", bus.c_valid_out, 1);
  endtask

  task automatic run1(input string tag, input op_t op, input logic s, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] ec, input logic eo, input logic ee);
    send(op, s, a, b);
    bus.in_valid_in = 1'b0;
    wait_valid();
    chk({tag, "_c"}, bus.c_out, ec);
    chk({tag, "_ovf"}, bus.ovf_out, eo);
    chk({tag, "_err"}, bus.err_out, ee);
    @(posedge clk); #1;
  endtask

  initial begin
    int   n0, accepted, k, r;
    logic acc;
    logic [W-1:0] held;
    corner[0] = 16'h8000; corner[1] = 16'h7FFF; corner[2] = 16'hFFFF;
    corner[3] = 16'h0000; corner[4] = 16'h0080; corner[5] = 16'h4000;
    bus.in_valid_in = 1'b0; bus.INS_in = '0; bus.sat_in = 1'b0;
    bus.a_in = '0; bus.b_in = '0; bus.c_ready_in = 1'b1; bus.clr_sticky_in = 1'b0;

    #1 rst_n = 1'b0;
    #10;
    chk("rst_valid", bus.c_valid_out, 0);
    chk("rst_ready", bus.in_ready_out, 1);
    chk("rst_c", bus.c_out, 0);
    chk("rst_ovf", bus.ovf_out, 0);
    chk("rst_err", bus.err_out, 0);
    chk("rst_sticky", bus.ovf_sticky_out, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run1("add_sat",  OP_ADD, 1'b1, 16'h4000, 16'h4000, 16'h7FFF, 1'b1, 1'b0);
    run1("add_wrap", OP_ADD, 1'b0, 16'h4000, 16'h4000, 16'h8000, 1'b1, 1'b0);
    chk("sticky_set", bus.ovf_sticky_out, 1);
    bus.clr_sticky_in = 1'b1;
    @(posedge clk); #1 bus.clr_sticky_in = 1'b0;
    chk("sticky_clr", bus.ovf_sticky_out, 0);

    run1("mul_pos",  OP_MUL, 1'b1, 16'h00C0, 16'h0100, 16'h0180, 1'b0, 1'b0);
    run1("mul_neg",  OP_MUL, 1'b1, 16'hFF80, 16'h0040, 16'hFFC0, 1'b0, 1'b0);
    run1("mul_min",  OP_MUL, 1'b1, 16'h8000, 16'h8000, 16'h7FFF, 1'b1, 1'b0);
    run1("sub_min",  OP_SUB, 1'b1, 16'h0000, 16'h8000, 16'h7FFF, 1'b1, 1'b0);
    run1("shl_sat",  OP_SHL, 1'b1, 16'h0100, 16'h0007, 16'h7FFF, 1'b1, 1'b0);
    run1("shr",      OP_SHR, 1'b0, 16'h8000, 16'h000F, 16'hFFFF, 1'b0, 1'b0);
    run1("min",      OP_MIN, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    run1("illegal",  8'h20,  1'b0, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1);

    // Back-to-back stream with downstream always ready.
    n0 = n_out;
    lat_on = 1'b1;
    for (int i = 0; i < 4; i++) send(OP_ADD, 1'b1, 16'(i * 3), 16'h0010);
    bus.in_valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 lat_on = 1'b0;
    chk("b2b_count", n_out - n0, 4);

    // Backpressure: third op must wait while the result is held.
    bus.c_ready_in = 1'b0;
    n0 = n_out;
    send(OP_ADD, 1'b0, 16'h0101, 16'h0202);
    send(OP_SUB, 1'b0, 16'h0050, 16'h0100);
    bus.in_valid_in = 1'b1; bus.INS_in = OP_XOR; bus.a_in = 16'hA5A5; bus.b_in = 16'h0FF0;
    @(negedge clk);
    held = bus.c_out;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", bus.in_ready_out, 0);
      chk("bp_valid", bus.c_valid_out, 1);
      chk("bp_hold", bus.c_out, held);
    end
    @(posedge clk); #1 bus.c_ready_in = 1'b1;
    send(OP_XOR, 1'b0, 16'hA5A5, 16'h0FF0);
    bus.in_valid_in = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("bp_drain", n_out - n0, 3);
    chk("bp_empty", exp_q.size(), 0);

    // Reset with both stages occupied.
    bus.c_ready_in = 1'b0;
    send(OP_MUL, 1'b0, 16'h0200, 16'h0300);
    send(OP_OR,  1'b0, 16'h1100, 16'h0011);
    bus.in_valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", bus.c_valid_out, 0);
    chk("rst_async_ready", bus.in_ready_out, 1);
    chk("rst_async_c", bus.c_out, 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    bus.c_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_stale", bus.c_valid_out, 0);
    end

    // Random traffic with random backpressure and sticky clears.
    @(posedge clk); #1;
    accepted = 0; k = 0;
    while (accepted < 300 && k < 6000) begin
      @(negedge clk); acc = bus.in_valid_in && bus.in_ready_out;
      @(posedge clk); #1; k++;
      if (acc) accepted++;
      if (acc || !bus.in_valid_in) begin
        if ($urandom_range(0, 3) != 0) begin
          r = $urandom_range(0, 13);
          bus.INS_in = (r < 12) ? op_t'(r) : op_t'($urandom_range(12, 255));
          bus.sat_in = 1'($urandom_range(0, 1));
          bus.a_in = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
          bus.b_in = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
          bus.in_valid_in = 1'b1;
        end else bus.in_valid_in = 1'b0;
      end
      bus.c_ready_in    = ($urandom_range(0, 3) != 0);
      bus.clr_sticky_in = ($urandom_range(0, 15) == 0);
    end
    chk("rnd_count", accepted, 300);
    bus.in_valid_in = 1'b0; bus.c_ready_in = 1'b1; bus.clr_sticky_in = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("final_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
